mips_reg_file_gen: RTL and testbench
====================================

# mips_reg_file_gen

Parametrised MIPS general-purpose register file for the coursework CPU. It replaces the fixed 32x32 file and adds:
- hardwired-zero register, write-to-read bypass and synchronous reset;
- a HI/LO register pair for MULT/DIV results;
- a pending-write scoreboard, so a multicycle datapath can stall reads of registers whose load or multiply has not yet written back.

It sits between decode (read ports, reserve) and writeback (write port), and exposes v0 to the test harness.

## Interface
- DATA_W, 32, register width in bits.
- NUM_REGS, 32, number of GPRs; power of two, at least 4.
- ADDR_W, $clog2(NUM_REGS), register address width.
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = no forwarding.
- CLK  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- raddr1, raddr2  in  ADDR_W  read addresses.
- rdata1, rdata2  out  DATA_W  read data.
- rbusy1, rbusy2  out  1  addressed register has a write pending.
- we  in  1  GPR write enable.
- waddr  in  ADDR_W  GPR write address.
- wdata  in  DATA_W  GPR write data.
- rsv_en  in  1  mark a register pending (issued, not yet written back).
- rsv_addr  in  ADDR_W  register to mark pending.
- hilo_we  in  1  write HI and LO together.
- hi_in, lo_in  in  DATA_W  HI/LO write data.
- hi_out, lo_out  out  DATA_W  HI/LO contents.
- hilo_busy  out  1  HI/LO write pending.
- hilo_rsv  in  1  mark HI/LO pending.
- register_v0  out  DATA_W  contents of register 2, bypass not applied.

## Operation
- **Reset:** rst high at an edge clears all GPRs, HI, LO, every pending bit and hilo_busy. rst overrides we, rsv_en, hilo_we and hilo_rsv in the same cycle.
- **Register 0:**
  - reads always return 0 with busy 0;
  - writes and reserves to address 0 are ignored, so no storage is needed for it.
- **GPR write:** at the edge with we=1 and waddr≠0, regs[waddr] ← wdata and pending[waddr] ← 0.
- **Reserve:** at the edge with rsv_en=1 and rsv_addr≠0, pending[rsv_addr] ← 1.
  - If a write and a reserve target the same register in the same cycle, the reserve wins: data is written and pending ends at 1, because a new producer has been issued.
- **Reads are combinational:** rdataN = regs[raddrN].
  - With BYPASS=1, if we=1, waddr=raddrN and raddrN≠0, then rdataN = wdata and rbusyN = 0.
  - Otherwise rbusyN = pending[raddrN].
- **HI/LO:** hilo_we writes both registers and clears hilo_busy; hilo_rsv sets hilo_busy. When both are asserted, hilo_rsv wins.
  - With BYPASS=1, hi_out and lo_out forward hi_in and lo_in while hilo_we=1, and hilo_busy reads 0.
- **Arithmetic:** none; data is stored as-is. Addresses at or above NUM_REGS cannot occur because ADDR_W is exact.

## Timing
- After reset, every output is 0: rdata, rbusy, hi_out, lo_out, hilo_busy and register_v0.
- **Write-to-read latency:**
  - BYPASS=1: 0 cycles, visible in the same cycle as we.
  - BYPASS=0: 1 cycle, visible after the edge.
- **Reserve-to-busy latency:** 1 cycle. Busy is visible after the rsv_en edge; no bypass applies to reserve.
- **register_v0:** always the registered value, updated 1 cycle after the write.
- **Reset asserted mid-operation:** state is cleared at that edge, and any write presented in the same cycle is lost.
- No handshake. The consumer stalls on rbusy and the CPU control issues reserves.

## Structure
- **Package mips_pkg:** REG_ZERO=0, REG_V0=2, default DATA_W, and a typedef for the register address.
- **Sub-module mips_reg_scoreboard:** holds the NUM_REGS pending bits plus hilo_busy. It has the set/clear priority logic and the busy lookup for each read port, and is instantiated once.
- **Top level:** storage array, HI/LO registers and bypass muxes.

## Test plan
- **Reset:** preload r5=0xDEADBEEF, HI=1, r7 pending; pulse rst for 1 cycle → all outputs 0, rbusy for r7 = 0.
- **Zero register:** write r0=0x1234 and reserve r0; read raddr1=0 → rdata1=0, rbusy1=0.
- **Bypass:** BYPASS=1, we with waddr=9, wdata=0xA5A5A5A5, raddr2=9 in the same cycle → rdata2=0xA5A5A5A5 that cycle.
  - Same stimulus with BYPASS=0 → old value that cycle, new value the next cycle.
- **Scoreboard:**
  - reserve r3 → rbusy1=1 on the next cycle; write r3=7 → busy 0 after the edge (0 in the write cycle with bypass);
  - write and reserve r3 in the same cycle → r3=7 and busy 1.
- **HI/LO:** hilo_rsv, then hilo_we with hi_in=0x1, lo_in=0xFFFFFFFE → hilo_busy 1 then 0, and hi_out/lo_out hold the values.
- **v0:** write r2=42 → register_v0=42 one cycle later; write r2 with rst asserted in the same cycle → register_v0 stays 0.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants and types for the MIPS register file
package mips_pkg;

  localparam int REG_ZERO       = 0;
  localparam int REG_V0         = 2;
  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 5;

  typedef logic [DEFAULT_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/mips_reg_scoreboard.sv
// rtl/mips_reg_scoreboard.sv - pending-write bits for the GPRs and HI/LO
// A reserve issued in the same cycle as a write-back wins: a new producer is in flight.
module mips_reg_scoreboard
  import mips_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int BYPASS   = 1
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              hilo_we,
  input  logic              hilo_rsv,
  output logic              rbusy1,
  output logic              rbusy2,
  output logic              hilo_busy
);

  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;
  logic                hilo_busy_q;
  logic                hilo_busy_d;
  logic                hit1;
  logic                hit2;

  always_comb begin
    pending_d   = pending_q;
    hilo_busy_d = hilo_busy_q;
    if (we && (waddr != ZERO_A)) begin
      pending_d[waddr] = 1'b0;
    end
    if (rsv_en && (rsv_addr != ZERO_A)) begin
      pending_d[rsv_addr] = 1'b1;
    end
    if (hilo_we) begin
      hilo_busy_d = 1'b0;
    end
    if (hilo_rsv) begin
      hilo_busy_d = 1'b1;
    end
    if (rst) begin
      pending_d   = '0;
      hilo_busy_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    pending_q   <= pending_d;
    hilo_busy_q <= hilo_busy_d;
  end

  // A forwarded write satisfies the reader this cycle, so it must not stall.
  assign hit1 = (BYPASS != 0) && we && (waddr == raddr1);
  assign hit2 = (BYPASS != 0) && we && (waddr == raddr2);

  assign rbusy1    = ((raddr1 == ZERO_A) || hit1) ? 1'b0 : pending_q[raddr1];
  assign rbusy2    = ((raddr2 == ZERO_A) || hit2) ? 1'b0 : pending_q[raddr2];
  assign hilo_busy = ((BYPASS != 0) && hilo_we) ? 1'b0 : hilo_busy_q;

endmodule

// File: rtl/mips_reg_file_gen.sv
// rtl/mips_reg_file_gen.sv - parametrised MIPS GPR file with HI/LO, bypass and scoreboard
// Register 0 has no storage; the array starts at index 1.
module mips_reg_file_gen
  import mips_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int BYPASS   = 1
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              rbusy1,
  output logic              rbusy2,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              hilo_we,
  input  logic [DATA_W-1:0] hi_in,
  input  logic [DATA_W-1:0] lo_in,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out,
  output logic              hilo_busy,
  input  logic              hilo_rsv,
  output logic [DATA_W-1:0] register_v0
);

  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs_q [1:NUM_REGS-1];
  logic [DATA_W-1:0] regs_d [1:NUM_REGS-1];
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] hi_d;
  logic [DATA_W-1:0] lo_q;
  logic [DATA_W-1:0] lo_d;
  logic [DATA_W-1:0] stored1;
  logic [DATA_W-1:0] stored2;
  logic              fwd1;
  logic              fwd2;

  always_comb begin
    regs_d = regs_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    if (rst) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_d[i] = '0;
      end
      hi_d = '0;
      lo_d = '0;
    end else begin
      if (we && (waddr != ZERO_A)) begin
        regs_d[waddr] = wdata;
      end
      if (hilo_we) begin
        hi_d = hi_in;
        lo_d = lo_in;
      end
    end
  end

  always_ff @(posedge CLK) begin
    regs_q <= regs_d;
    hi_q   <= hi_d;
    lo_q   <= lo_d;
  end

  assign stored1 = (raddr1 == ZERO_A) ? '0 : regs_q[raddr1];
  assign stored2 = (raddr2 == ZERO_A) ? '0 : regs_q[raddr2];

  assign fwd1 = (BYPASS != 0) && we && (waddr == raddr1) && (raddr1 != ZERO_A);
  assign fwd2 = (BYPASS != 0) && we && (waddr == raddr2) && (raddr2 != ZERO_A);

  assign rdata1 = fwd1 ? wdata : stored1;
  assign rdata2 = fwd2 ? wdata : stored2;

  assign hi_out = ((BYPASS != 0) && hilo_we) ? hi_in : hi_q;
  assign lo_out = ((BYPASS != 0) && hilo_we) ? lo_in : lo_q;

  // The harness wants the committed v0, never the forwarded value.
  assign register_v0 = regs_q[REG_V0];

  mips_reg_scoreboard #(
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W),
    .BYPASS  (BYPASS)
  ) u_scoreboard (
    .CLK      (CLK),
    .rst      (rst),
    .raddr1   (raddr1),
    .raddr2   (raddr2),
    .we       (we),
    .waddr    (waddr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .hilo_we  (hilo_we),
    .hilo_rsv (hilo_rsv),
    .rbusy1   (rbusy1),
    .rbusy2   (rbusy2),
    .hilo_busy(hilo_busy)
  );

endmodule

// File: tb/tb_mips_reg_file_gen.sv
// tb/tb_mips_reg_file_gen.sv - directed bench for mips_reg_file_gen, bypass and no-bypass builds
module tb_mips_reg_file_gen;

  logic        CLK = 1'b0;
  logic        rst;
  logic [4:0]  raddr1, raddr2, waddr, rsv_addr;
  logic        we, rsv_en, hilo_we, hilo_rsv;
  logic [31:0] wdata, hi_in, lo_in;

  logic [31:0] b_rdata1, b_rdata2, b_hi, b_lo, b_v0;
  logic        b_rbusy1, b_rbusy2, b_hbusy;
  logic [31:0] n_rdata1, n_rdata2, n_hi, n_lo, n_v0;
  logic        n_rbusy1, n_rbusy2, n_hbusy;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 CLK = ~CLK;

  mips_reg_file_gen #(.BYPASS(1)) u_dut_b (
    .CLK(CLK), .rst(rst), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(b_rdata1), .rdata2(b_rdata2), .rbusy1(b_rbusy1), .rbusy2(b_rbusy2),
    .we(we), .waddr(waddr), .wdata(wdata), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .hilo_we(hilo_we), .hi_in(hi_in), .lo_in(lo_in), .hi_out(b_hi), .lo_out(b_lo),
    .hilo_busy(b_hbusy), .hilo_rsv(hilo_rsv), .register_v0(b_v0)
  );

  mips_reg_file_gen #(.BYPASS(0)) u_dut_n (
    .CLK(CLK), .rst(rst), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(n_rdata1), .rdata2(n_rdata2), .rbusy1(n_rbusy1), .rbusy2(n_rbusy2),
    .we(we), .waddr(waddr), .wdata(wdata), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .hilo_we(hilo_we), .hi_in(hi_in), .lo_in(lo_in), .hi_out(n_hi), .lo_out(n_lo),
    .hilo_busy(n_hbusy), .hilo_rsv(hilo_rsv), .register_v0(n_v0)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    we = 0; rsv_en = 0; hilo_we = 0; hilo_rsv = 0;
    waddr = 0; wdata = 0; rsv_addr = 0; hi_in = 0; lo_in = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle(); raddr1 = 0; raddr2 = 0;
    tick(); tick();
    rst = 0;
    we = 1; waddr = 5; wdata = 32'hDEADBEEF; tick();
    idle(); hilo_we = 1; hi_in = 32'h1; tick();
    idle(); rsv_en = 1; rsv_addr = 7; tick();
    idle(); raddr1 = 5; raddr2 = 7; #1;
    tests_run++; if (b_rdata1 !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL preload_r5 got %h want deadbeef", b_rdata1); end
    tests_run++; if (b_rbusy2 !== 1'b1) begin tests_failed++; $display("FAIL preload_busy7 got %b want 1", b_rbusy2); end
    tests_run++; if (b_hi !== 32'h1) begin tests_failed++; $display("FAIL preload_hi got %h want 1", b_hi); end
    rst = 1; tick(); rst = 0; #1;
    tests_run++; if (b_rdata1 !== 32'h0) begin tests_failed++; $display("FAIL reset_rdata1 got %h want 0", b_rdata1); end
    tests_run++; if (b_rbusy2 !== 1'b0) begin tests_failed++; $display("FAIL reset_rbusy2 got %b want 0", b_rbusy2); end
    tests_run++; if (b_hi !== 32'h0 || b_lo !== 32'h0) begin tests_failed++; $display("FAIL reset_hilo got %h/%h want 0/0", b_hi, b_lo); end
    tests_run++; if (b_hbusy !== 1'b0 || b_v0 !== 32'h0) begin tests_failed++; $display("FAIL reset_hbusy_v0 got %b/%h want 0/0", b_hbusy, b_v0); end
    tests_run++; if (n_rdata1 !== 32'h0 || n_rbusy2 !== 1'b0) begin tests_failed++; $display("FAIL reset_nobypass got %h/%b want 0/0", n_rdata1, n_rbusy2); end
  endtask

  task automatic test_zero_reg();
    idle(); raddr1 = 0;
    we = 1; waddr = 0; wdata = 32'h1234; rsv_en = 1; rsv_addr = 0; #1;
    tests_run++; if (b_rdata1 !== 32'h0) begin tests_failed++; $display("FAIL zero_no_forward got %h want 0", b_rdata1); end
    tick(); idle(); #1;
    tests_run++; if (b_rdata1 !== 32'h0 || b_rbusy1 !== 1'b0) begin tests_failed++; $display("FAIL zero_read got %h/%b want 0/0", b_rdata1, b_rbusy1); end
    tests_run++; if (n_rdata1 !== 32'h0 || n_rbusy1 !== 1'b0) begin tests_failed++; $display("FAIL zero_read_nb got %h/%b want 0/0", n_rdata1, n_rbusy1); end
  endtask

  task automatic test_bypass();
    idle(); raddr2 = 9;
    we = 1; waddr = 9; wdata = 32'hA5A5A5A5; #1;
    tests_run++; if (b_rdata2 !== 32'hA5A5A5A5) begin tests_failed++; $display("FAIL bypass_same_cycle got %h want a5a5a5a5", b_rdata2); end
    tests_run++; if (n_rdata2 !== 32'h0) begin tests_failed++; $display("FAIL nobypass_old got %h want 0", n_rdata2); end
    tick(); idle(); #1;
    tests_run++; if (n_rdata2 !== 32'hA5A5A5A5) begin tests_failed++; $display("FAIL nobypass_next got %h want a5a5a5a5", n_rdata2); end
    tests_run++; if (b_rdata2 !== 32'hA5A5A5A5) begin tests_failed++; $display("FAIL bypass_next got %h want a5a5a5a5", b_rdata2); end
  endtask

  task automatic test_scoreboard();
    idle(); raddr1 = 3;
    rsv_en = 1; rsv_addr = 3; #1;
    tests_run++; if (b_rbusy1 !== 1'b0) begin tests_failed++; $display("FAIL rsv_no_bypass got %b want 0", b_rbusy1); end
    tick(); idle(); #1;
    tests_run++; if (b_rbusy1 !== 1'b1 || n_rbusy1 !== 1'b1) begin tests_failed++; $display("FAIL rsv_busy got %b/%b want 1/1", b_rbusy1, n_rbusy1); end
    we = 1; waddr = 3; wdata = 32'd7; #1;
    tests_run++; if (b_rbusy1 !== 1'b0 || b_rdata1 !== 32'd7) begin tests_failed++; $display("FAIL wb_bypass got %b/%h want 0/7", b_rbusy1, b_rdata1); end
    tests_run++; if (n_rbusy1 !== 1'b1 || n_rdata1 !== 32'd0) begin tests_failed++; $display("FAIL wb_nobypass got %b/%h want 1/0", n_rbusy1, n_rdata1); end
    tick(); idle(); #1;
    tests_run++; if (b_rbusy1 !== 1'b0 || n_rbusy1 !== 1'b0 || n_rdata1 !== 32'd7) begin tests_failed++; $display("FAIL wb_after got %b/%b/%h want 0/0/7", b_rbusy1, n_rbusy1, n_rdata1); end
    we = 1; waddr = 3; wdata = 32'd1; tick();
    idle(); we = 1; waddr = 3; wdata = 32'd7; rsv_en = 1; rsv_addr = 3; #1;
    tests_run++; if (b_rbusy1 !== 1'b0 || b_rdata1 !== 32'd7) begin tests_failed++; $display("FAIL wr_rsv_fwd got %b/%h want 0/7", b_rbusy1, b_rdata1); end
    tick(); idle(); #1;
    tests_run++; if (b_rbusy1 !== 1'b1 || b_rdata1 !== 32'd7) begin tests_failed++; $display("FAIL wr_rsv got %b/%h want 1/7", b_rbusy1, b_rdata1); end
    tests_run++; if (n_rbusy1 !== 1'b1 || n_rdata1 !== 32'd7) begin tests_failed++; $display("FAIL wr_rsv_nb got %b/%h want 1/7", n_rbusy1, n_rdata1); end
  endtask

  task automatic test_hilo();
    idle(); hilo_rsv = 1; tick(); idle(); #1;
    tests_run++; if (b_hbusy !== 1'b1 || n_hbusy !== 1'b1) begin tests_failed++; $display("FAIL hilo_rsv got %b/%b want 1/1", b_hbusy, n_hbusy); end
    hilo_we = 1; hi_in = 32'h1; lo_in = 32'hFFFFFFFE; #1;
    tests_run++; if (b_hbusy !== 1'b0 || b_hi !== 32'h1 || b_lo !== 32'hFFFFFFFE) begin tests_failed++; $display("FAIL hilo_fwd got %b/%h/%h want 0/1/fffffffe", b_hbusy, b_hi, b_lo); end
    tests_run++; if (n_hbusy !== 1'b1 || n_hi !== 32'h0) begin tests_failed++; $display("FAIL hilo_nofwd got %b/%h want 1/0", n_hbusy, n_hi); end
    tick(); idle(); #1;
    tests_run++; if (n_hbusy !== 1'b0 || n_hi !== 32'h1 || n_lo !== 32'hFFFFFFFE) begin tests_failed++; $display("FAIL hilo_after got %b/%h/%h want 0/1/fffffffe", n_hbusy, n_hi, n_lo); end
    hilo_we = 1; hilo_rsv = 1; hi_in = 32'h22; lo_in = 32'h33; tick(); idle(); #1;
    tests_run++; if (b_hbusy !== 1'b1 || b_hi !== 32'h22 || b_lo !== 32'h33) begin tests_failed++; $display("FAIL hilo_rsv_wins got %b/%h/%h want 1/22/33", b_hbusy, b_hi, b_lo); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v1, v2;
    idle();
    for (int i = 1; i < 32; i++) begin
      we = 1; waddr = 5'(i); wdata = (32'h01010101 * i) ^ 32'h000000C3; tick();
    end
    idle();
    for (int i = 1; i < 32; i++) begin
      raddr1 = 5'(i); raddr2 = 5'(32 - i); #1;
      v1 = (32'h01010101 * i) ^ 32'h000000C3;
      v2 = (32'h01010101 * (32 - i)) ^ 32'h000000C3;
      tests_run++; if (b_rdata1 !== v1 || b_rdata2 !== v2 || b_rbusy1 !== 1'b0) begin tests_failed++; $display("FAIL b2b_r%0d got %h/%h/%b want %h/%h/0", i, b_rdata1, b_rdata2, b_rbusy1, v1, v2); end
      tests_run++; if (n_rdata1 !== v1 || n_rdata2 !== v2) begin tests_failed++; $display("FAIL b2b_nb_r%0d got %h/%h want %h/%h", i, n_rdata1, n_rdata2, v1, v2); end
    end
  endtask

  task automatic test_v0();
    idle(); rst = 1; tick(); rst = 0;
    raddr1 = 2; we = 1; waddr = 2; wdata = 32'd42; #1;
    tests_run++; if (b_v0 !== 32'd0 || b_rdata1 !== 32'd42) begin tests_failed++; $display("FAIL v0_same_cycle got %h/%h want 0/2a", b_v0, b_rdata1); end
    tick(); idle(); #1;
    tests_run++; if (b_v0 !== 32'd42 || n_v0 !== 32'd42) begin tests_failed++; $display("FAIL v0_next got %h/%h want 2a/2a", b_v0, n_v0); end
    rst = 1; we = 1; waddr = 2; wdata = 32'd99; tick(); rst = 0; idle(); #1;
    tests_run++; if (b_v0 !== 32'd0 || b_rdata1 !== 32'd0) begin tests_failed++; $display("FAIL v0_rst_write got %h/%h want 0/0", b_v0, b_rdata1); end
  endtask

  initial begin
    test_reset();
    test_zero_reg();
    test_bypass();
    test_scoreboard();
    test_hilo();
    test_back_to_back();
    test_v0();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
